ce_delay_after_reset_mc: RTL and testbench
==========================================

Name: ce_delay_after_reset_mc

Overview:
Multi-channel, runtime-programmable successor to the single-channel CE-delay-after-reset gate. Each channel blocks the shared clock-enable CE for a programmed number of events after RESET or after a per-channel re-arm, then passes CE through. The counted event is either a clock cycle or a CE pulse, selected by parameter. It sits between the sensor front-end CE generator and downstream filter/measurement pipelines that must ignore samples while their pipelines flush.

Parameters:
CHANNELS, 4, number of independent gated CE outputs (1..32)
MAX_DELAY, 255, largest programmable delay; counter width DW = $clog2(MAX_DELAY+1)
COUNT_CE, 0, 0 = delay counts clock cycles; 1 = delay counts cycles with CE=1

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
CE  in  1  shared input clock enable
REARM  in  CHANNELS  per-channel synchronous restart of the delay
DELAY_CFG  in  CHANNELS*DW  per-channel delay, channel i at bits [i*DW +: DW]; latched only on RESET/REARM
CE_OUT  out  CHANNELS  gated CE per channel
READY  out  CHANNELS  1 when channel is in RUN
ALL_READY  out  1  AND of READY

Behaviour:
- Per-channel state: WAIT or RUN, plus a DW-bit down-counter cnt.
- Load event (RESET=1, or REARM[i]=1 with RESET=0), at that clock edge: cnt <= DELAY_CFG[i]; state <= RUN if DELAY_CFG[i]==0, else WAIT.
- RESET has priority over REARM. REARM has priority over a counting event in the same cycle.
- Counting event: COUNT_CE=0 means every clock with RESET=0 and REARM[i]=0. COUNT_CE=1 means the same, additionally qualified by CE=1.
- WAIT, on a counting event: if cnt==1, then state <= RUN and cnt <= 0; else cnt <= cnt-1. With no event, hold.
- RUN: hold until the next load event.
- CE_OUT[i] = CE & READY[i] & ~RESET. This is combinational from CE, so CE_OUT has zero latency in RUN.
- READY[i] = (state==RUN), registered.
- Result with COUNT_CE=0, delay D, RESET high for edge e0:
  - CE_OUT is 0 during the D cycles following e0.
  - CE_OUT follows CE from cycle D+1 onward.
- Result with COUNT_CE=1: the first D CE pulses after release are suppressed; pulse D+1 and later pass.
- Reset values: all channels take their load value. With any DELAY_CFG nonzero: READY=0, CE_OUT=0, ALL_READY=0.
- DELAY_CFG changes while a channel is in WAIT or RUN are ignored until the next load event.
- REARM held high keeps the channel reloading: no counting, CE_OUT=0 (unless DELAY_CFG==0).
- DELAY_CFG values above MAX_DELAY are impossible by width; no saturation logic.
- The counter never wraps: it stops at 0 in RUN.
- Reset mid-WAIT or mid-RUN: immediate reload; the in-progress count is discarded.

Decomposition:
- Package ce_delay_pkg holds:
  - typedef enum logic {WAIT, RUN} ce_delay_state_t;
  - a function returning DW for a given MAX_DELAY.
- Sub-module ce_delay_channel (one state/counter, inputs load, load_value, count_en; outputs ready). The top generates CHANNELS instances and does the CE gating and ALL_READY reduction.

Test Plan:
- Delay sweep: CHANNELS=4, COUNT_CE=0, DELAY_CFG={0,1,2,16}, CE=1 constant, RESET for 1 cycle -> CE_OUT[0]=1 on the first cycle after release; CE_OUT[1], [2], [3] first go high on cycle 2, 3, 17 respectively; ALL_READY high from cycle 17.
- CE-count mode: COUNT_CE=1, delay 3, CE toggling 1-0-1-0 -> the first three CE pulses are suppressed, the fourth passes; READY rises on the edge of the third pulse.
- Rearm isolation: after all channels are in RUN, pulse REARM[2] with delay 5 -> only CE_OUT[2] drops for 5 cycles; other channels are unaffected; ALL_READY low for those 5 cycles.
- Priority: assert RESET and REARM[1] together, then REARM on the final count cycle -> RESET reload on all channels; the REARM reload wins and the channel stays in WAIT with cnt=DELAY_CFG.
- Mid-operation reset: RESET at WAIT cnt=7 of 16 -> full 16-cycle delay restarts. A DELAY_CFG change during WAIT has no effect until the next REARM.
- Max delay: MAX_DELAY=255, delay 255 -> exactly 255 blocked cycles; no wrap after 300 further cycles.

Source files
------------

// File: rtl/ce_delay_pkg.sv
// Shared types and helpers for the multi-channel CE-delay-after-reset gate.
package ce_delay_pkg;

  typedef enum logic {WAIT = 1'b0, RUN = 1'b1} ce_delay_state_t;

  // Counter width needed to hold 0..max_delay, never narrower than one bit.
  function automatic int calc_dw(input int max_delay);
    int w;
    w = $clog2(max_delay + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/ce_delay_channel.sv
// One gated-CE channel: WAIT/RUN state plus a down-counter reloaded on every load event.
module ce_delay_channel
  import ce_delay_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          load,
  input  logic [DW-1:0] load_value,
  input  logic          count_en,
  output logic          ready
);

  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_ZERO = '0;

  ce_delay_state_t state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      cnt_d   = load_value;
      state_d = (load_value == CNT_ZERO) ? RUN : WAIT;
    end else if (count_en && (state_q == WAIT)) begin
      // cnt is never 0 in WAIT; <= keeps the counter from ever wrapping
      if (cnt_q <= CNT_ONE) begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // load is driven by RESET at the top, so it doubles as the synchronous reset
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign ready = (state_q == RUN);

endmodule

// File: rtl/ce_delay_after_reset_mc.sv
// Multi-channel CE gate: each channel blocks CE for a programmed number of events after RESET/REARM.
module ce_delay_after_reset_mc
  import ce_delay_pkg::*;
#(
  parameter  int CHANNELS  = 4,
  parameter  int MAX_DELAY = 255,
  parameter  int COUNT_CE  = 0,
  localparam int DW        = calc_dw(MAX_DELAY)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic [CHANNELS-1:0]    REARM,
  input  logic [CHANNELS*DW-1:0] DELAY_CFG,
  output logic [CHANNELS-1:0]    CE_OUT,
  output logic [CHANNELS-1:0]    READY,
  output logic                   ALL_READY
);

  logic                count_base;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] count_en;
  logic [CHANNELS-1:0] ready;

  assign count_base = (COUNT_CE != 0) ? CE : 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign load[g]     = RESET | REARM[g];
    assign count_en[g] = ~load[g] & count_base;

    ce_delay_channel #(
      .DW (DW)
    ) u_ch (
      .clk        (CLK),
      .load       (load[g]),
      .load_value (DELAY_CFG[g*DW +: DW]),
      .count_en   (count_en[g]),
      .ready      (ready[g])
    );
  end

  // CE passes straight through in RUN; RESET masks it in the cycle it is asserted
  assign CE_OUT    = ready & {CHANNELS{CE & ~RESET}};
  assign READY     = ready;
  assign ALL_READY = &ready;

endmodule

// File: tb/tb_ce_delay_after_reset_mc.sv
// Bench for ce_delay_after_reset_mc: cycle-count and CE-count instances against an events-since-load model.
module tb_ce_delay_after_reset_mc;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                ce;
  logic [NCH-1:0]      rearm;
  logic [NCH*DW-1:0]   cfg;
  logic [NCH-1:0]      ce_out0, ready0, ce_out1, ready1;
  logic                all0, all1;

  int checks   = 0;
  int failures = 0;

  // model: latched delay and number of counting events since the last load
  int m_lat [2][NCH];
  int m_ev  [2][NCH];
  bit m_valid = 1'b0;

  logic [NCH-1:0] s_ce0, s_ce1, s_rdy0;
  logic           s_all0;

  always #5 clk = ~clk;

  ce_delay_after_reset_mc #(.CHANNELS(NCH), .MAX_DELAY(255), .COUNT_CE(0)) dut0 (
    .CLK(clk), .RESET(reset), .CE(ce), .REARM(rearm), .DELAY_CFG(cfg),
    .CE_OUT(ce_out0), .READY(ready0), .ALL_READY(all0)
  );

  ce_delay_after_reset_mc #(.CHANNELS(NCH), .MAX_DELAY(255), .COUNT_CE(1)) dut1 (
    .CLK(clk), .RESET(reset), .CE(ce), .REARM(rearm), .DELAY_CFG(cfg),
    .CE_OUT(ce_out1), .READY(ready1), .ALL_READY(all1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int v);
    cfg[ch*DW +: DW] = DW'(v);
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] er;
    logic [NCH-1:0] ec;
    for (int d = 0; d < 2; d++) begin
      er = '0;
      for (int i = 0; i < NCH; i++) er[i] = (m_ev[d][i] >= m_lat[d][i]);
      ec = er & {NCH{ce & ~reset}};
      if (d == 0) begin
        chk("cyc_ready", 32'(ready0), 32'(er));
        chk("cyc_ce_out", 32'(ce_out0), 32'(ec));
        chk("cyc_all_ready", 32'(all0), 32'(&er));
      end else begin
        chk("cemode_ready", 32'(ready1), 32'(er));
        chk("cemode_ce_out", 32'(ce_out1), 32'(ec));
        chk("cemode_all_ready", 32'(all1), 32'(&er));
      end
    end
  endtask

  // inputs are already driven (at negedge); check this cycle, advance the model at the edge
  task automatic tick();
    #1;
    s_ce0  = ce_out0;
    s_ce1  = ce_out1;
    s_rdy0 = ready0;
    s_all0 = all0;
    if (m_valid) check_outputs();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        if (reset || rearm[i]) begin
          m_lat[d][i] = int'(cfg[i*DW +: DW]);
          m_ev[d][i]  = 0;
        end else if ((d == 0 || ce) && m_ev[d][i] < 100000) begin
          m_ev[d][i] = m_ev[d][i] + 1;
        end
      end
    end
    if (reset) m_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int first [NCH];
    int first_all;
    int pulses;
    int first_pass;
    int blk;
    int blk_other;
    int all_low;

    reset = 1'b1; ce = 1'b1; rearm = '0; cfg = '0;
    @(negedge clk);

    // delay sweep {0,1,2,16}
    set_cfg(0, 0); set_cfg(1, 1); set_cfg(2, 2); set_cfg(3, 16);
    tick();
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) first[i] = 0;
    first_all = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int i = 0; i < NCH; i++) if (s_ce0[i] && first[i] == 0) first[i] = k;
      if (s_all0 && first_all == 0) first_all = k;
    end
    chk("sweep_first_ch0", first[0], 1);
    chk("sweep_first_ch1", first[1], 2);
    chk("sweep_first_ch2", first[2], 3);
    chk("sweep_first_ch3", first[3], 17);
    chk("sweep_first_all_ready", first_all, 17);

    // CE-count mode: delay 3 with CE toggling
    set_cfg(0, 3);
    reset = 1'b1; ce = 1'b0;
    tick();
    reset = 1'b0;
    pulses = 0; first_pass = 0;
    for (int p = 0; p < 16; p++) begin
      ce = (p % 2 == 0);
      tick();
      if (ce) begin
        pulses++;
        if (s_ce1[0] && first_pass == 0) first_pass = pulses;
        if (pulses == 3) chk("cemode_ready_after_pulse3", 32'(ready1[0]), 1);
      end
    end
    chk("cemode_first_passing_pulse", first_pass, 4);

    // rearm isolation on channel 2
    ce = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("rearm_pre_all_ready", 32'(all0), 1);
    set_cfg(2, 5);
    rearm = 4'b0100;
    tick();
    rearm = '0;
    blk = 0; blk_other = 0; all_low = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!s_ce0[2]) blk++;
      if ((s_ce0 & 4'b1011) != 4'b1011) blk_other++;
      if (!s_all0) all_low++;
    end
    chk("rearm_ch2_blocked", blk, 5);
    chk("rearm_others_blocked", blk_other, 0);
    chk("rearm_all_ready_low", all_low, 5);

    // RESET with REARM, then REARM on the final count cycle
    set_cfg(1, 4);
    reset = 1'b1; rearm = 4'b0010;
    tick();
    reset = 1'b0; rearm = '0;
    for (int k = 0; k < 3; k++) tick();
    rearm = 4'b0010;
    tick();
    rearm = '0;
    chk("prio_ch1_still_wait", 32'(ready0[1]), 0);
    blk = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_ce0[1]) blk++;
    end
    chk("prio_ch1_blocked", blk, 4);

    // mid-WAIT reset, then a DELAY_CFG change during WAIT
    set_cfg(3, 16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_cfg(3, 3);
    blk = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!s_ce0[3]) blk++;
    end
    chk("midreset_ch3_blocked", blk, 16);
    rearm = 4'b1000;
    tick();
    rearm = '0;
    blk = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_ce0[3]) blk++;
    end
    chk("newcfg_ch3_blocked", blk, 3);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      ce    = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NCH; i++) begin
        rearm[i] = ($urandom_range(0, 15) == 0);
        set_cfg(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20)));
      end
      tick();
    end
    reset = 1'b0; rearm = '0;

    // max delay: 255 blocked cycles, no wrap afterwards
    set_cfg(0, 255);
    ce = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    blk = 0; blk_other = 0;
    for (int k = 1; k <= 555; k++) begin
      tick();
      if (!s_ce0[0]) blk++;
      if (k > 255 && !s_rdy0[0]) blk_other++;
    end
    chk("maxdelay_blocked", blk, 255);
    chk("maxdelay_no_wrap", blk_other, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
